// File: rtl/mem_bus_arbiter_pkg.sv
// rtl/mem_bus_arbiter_pkg.sv - shared widths, bus addresses and OAM DMA state encoding
// Contents: default data/address widths, the DMA trigger and OAM data
// addresses, and the 3-bit DMA sequencer state type.
package mem_bus_arbiter_pkg;

  localparam int DEF_REG_WIDTH  = 8;
  localparam int DEF_ADDR_WIDTH = 16;

  localparam logic [15:0] DEF_DMA_TRIGGER_ADDR = 16'h4014;
  localparam logic [15:0] DEF_OAM_DATA_ADDR    = 16'h2004;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ALIGN0 = 3'd1,
    ST_ALIGN1 = 3'd2,
    ST_DMA_RD = 3'd3,
    ST_DMA_WR = 3'd4
  } dma_state_e;

endpackage

// File: rtl/mem_bus_arbiter_oam_dma_seq.sv
// rtl/mem_bus_arbiter_oam_dma_seq.sv - OAM DMA sequencer: 256-byte page copy to the OAM data port
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   trigger           granted executor write to the trigger address (IDLE only)
//   trigger_page      source page (executor write data)
//   mem_rdata         combinational bus read data
//   active            sequencer owns the bus (state != IDLE)
//   dma_req           sequencer drives a bus access this cycle
//   dma_we            access is a write
//   dma_addr          access address
//   dma_wdata         write data
module oam_dma_seq
  import mem_bus_arbiter_pkg::*;
#(
  parameter int                    REG_WIDTH     = DEF_REG_WIDTH,
  parameter int                    ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] OAM_DATA_ADDR = DEF_OAM_DATA_ADDR
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  trigger,
  input  logic [REG_WIDTH-1:0]  trigger_page,
  input  logic [REG_WIDTH-1:0]  mem_rdata,
  output logic                  active,
  output logic                  dma_req,
  output logic                  dma_we,
  output logic [ADDR_WIDTH-1:0] dma_addr,
  output logic [REG_WIDTH-1:0]  dma_wdata
);

  dma_state_e           state, state_next;
  logic                 parity;
  logic                 odd_start;
  logic [REG_WIDTH-1:0] page;
  logic [7:0]           idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      parity    <= 1'b0;
      odd_start <= 1'b0;
      page      <= '0;
      idx       <= '0;
    end else begin
      state  <= state_next;
      parity <= ~parity;
      if (state == ST_IDLE && trigger) begin
        page      <= trigger_page;
        idx       <= '0;
        odd_start <= parity;
      end
      // idx is 8 bits wide, so the step after 8'hFF wraps to 0 and page stays put
      if (state == ST_DMA_WR) begin
        idx <= idx + 8'd1;
      end
    end
  end

  always_comb begin
    state_next = state;
    dma_req    = 1'b0;
    dma_we     = 1'b0;
    dma_addr   = OAM_DATA_ADDR;
    // The DMA_WR state coincides with the bus cycle of the preceding read, so
    // the byte is taken straight off mem_rdata; the mem_wdata register in the
    // arbiter then holds it as the copy buffer during the write bus cycle.
    dma_wdata  = mem_rdata;
    case (state)
      ST_IDLE:   if (trigger) state_next = ST_ALIGN0;
      ST_ALIGN0: state_next = odd_start ? ST_ALIGN1 : ST_DMA_RD;
      ST_ALIGN1: state_next = ST_DMA_RD;
      ST_DMA_RD: begin
        dma_req    = 1'b1;
        dma_addr   = ADDR_WIDTH'({page, idx});
        state_next = ST_DMA_WR;
      end
      ST_DMA_WR: begin
        dma_req    = 1'b1;
        dma_we     = 1'b1;
        state_next = (idx == 8'hFF) ? ST_IDLE : ST_DMA_RD;
      end
      default:   state_next = ST_IDLE;
    endcase
  end

  assign active = (state != ST_IDLE);

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - CPU memory port arbiter: executor > fetcher, OAM DMA stalls the CPU
// Ports:
//   phi1, reset                            clock, synchronous active-high reset
//   fetch_req/addr, fetch_gnt/valid        fetcher read channel
//   exec_req/we/addr/wdata, exec_gnt/valid executor read/write channel
//   rdata                                  registered read data for *_valid
//   mem_addr/we/wdata, mem_rdata           registered bus outputs, combinational read data
//   cpu_stall, dma_active                  DMA owns the bus
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int                    REG_WIDTH        = DEF_REG_WIDTH,
  parameter int                    ADDR_WIDTH       = DEF_ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] DMA_TRIGGER_ADDR = DEF_DMA_TRIGGER_ADDR,
  parameter logic [ADDR_WIDTH-1:0] OAM_DATA_ADDR    = DEF_OAM_DATA_ADDR
) (
  input  logic                  phi1,
  input  logic                  reset,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic                  fetch_gnt,
  output logic                  fetch_valid,
  input  logic                  exec_req,
  input  logic                  exec_we,
  input  logic [ADDR_WIDTH-1:0] exec_addr,
  input  logic [REG_WIDTH-1:0]  exec_wdata,
  output logic                  exec_gnt,
  output logic                  exec_valid,
  output logic [REG_WIDTH-1:0]  rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [REG_WIDTH-1:0]  mem_wdata,
  input  logic [REG_WIDTH-1:0]  mem_rdata,
  output logic                  cpu_stall,
  output logic                  dma_active
);

  logic                  dma_busy;
  logic                  dma_req;
  logic                  dma_we;
  logic [ADDR_WIDTH-1:0] dma_addr;
  logic [REG_WIDTH-1:0]  dma_wdata;
  logic                  trigger;
  logic                  rd_fetch_pend;
  logic                  rd_exec_pend;

  // Grants only exist while the sequencer is idle; the executor always wins.
  assign exec_gnt  = exec_req & ~dma_busy;
  assign fetch_gnt = fetch_req & ~exec_req & ~dma_busy;
  assign trigger   = exec_gnt & exec_we & (exec_addr == DMA_TRIGGER_ADDR);

  oam_dma_seq #(
    .REG_WIDTH    (REG_WIDTH),
    .ADDR_WIDTH   (ADDR_WIDTH),
    .OAM_DATA_ADDR(OAM_DATA_ADDR)
  ) u_dma (
    .clk         (phi1),
    .reset       (reset),
    .trigger     (trigger),
    .trigger_page(exec_wdata),
    .mem_rdata   (mem_rdata),
    .active      (dma_busy),
    .dma_req     (dma_req),
    .dma_we      (dma_we),
    .dma_addr    (dma_addr),
    .dma_wdata   (dma_wdata)
  );

  always_ff @(posedge phi1) begin
    if (reset) begin
      mem_addr      <= '0;
      mem_we        <= 1'b0;
      mem_wdata     <= '0;
      rd_fetch_pend <= 1'b0;
      rd_exec_pend  <= 1'b0;
      rdata         <= '0;
      fetch_valid   <= 1'b0;
      exec_valid    <= 1'b0;
    end else begin
      // Return path: a read whose bus cycle is ending now gets its data
      // registered and flagged for the requester in the following cycle.
      fetch_valid <= rd_fetch_pend;
      exec_valid  <= rd_exec_pend;
      if (rd_fetch_pend || rd_exec_pend) begin
        rdata <= mem_rdata;
      end
      rd_fetch_pend <= fetch_gnt;
      rd_exec_pend  <= exec_gnt & ~exec_we;

      mem_we <= 1'b0;
      if (dma_req) begin
        mem_addr  <= dma_addr;
        mem_we    <= dma_we;
        mem_wdata <= dma_wdata;
      end else if (exec_gnt) begin
        mem_addr  <= exec_addr;
        mem_we    <= exec_we;
        mem_wdata <= exec_wdata;
      end else if (fetch_gnt) begin
        mem_addr  <= fetch_addr;
      end
    end
  end

  assign cpu_stall  = dma_busy;
  assign dma_active = dma_busy;

endmodule
